// File: rtl/funct_generator_register_bank.sv
// funct_generator_register_bank
//   Multi-channel shadow/active register bank for the waveform generator.
//   Writes land in per-channel shadow registers; a commit copies every shadow
//   into its active register in one cycle, either as soon as the commit is
//   latched (SYNC_MODE=0) or at the next generator period strobe
//   (SYNC_MODE=1), with an optional timeout that forces the copy.
//
// Ports
//   clk, rst           clock, asynchronous active-low reset
//   clrh               synchronous clear of shadow + active to RESET_VEC
//   wr_en/addr/data    shadow write
//   commit_req         request shadow->active transfer (pulse or level)
//   sync               period-boundary strobe from the generator
//   rd_addr/rd_data    registered shadow readback (0 for unused addresses)
//   q                  packed active registers, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   dirty              per-channel "shadow written since last transfer"
//   pending            commit latched, transfer not yet done
//   commit_done        one-cycle pulse after a transfer
//   timeout            one-cycle pulse (with commit_done) when the transfer was forced
//   wr_err             one-cycle pulse on a write to an unused address

// Per-channel shadow/active pair with its dirty flag.
module funct_generator_register_bank_ch #(
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clrh,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  xfer,
    output logic [DATA_WIDTH-1:0] shadow,
    output logic [DATA_WIDTH-1:0] active,
    output logic                  dirty
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow <= RST_VAL;
            active <= RST_VAL;
            dirty  <= 1'b0;
        end else if (clrh) begin
            shadow <= RST_VAL;
            active <= RST_VAL;
            dirty  <= 1'b0;
        end else begin
            // active samples the pre-write shadow, so a write colliding with
            // a transfer is held back for the next commit and stays dirty
            if (xfer) active <= shadow;
            if (wr)   shadow <= wr_data;
            if (wr)        dirty <= 1'b1;
            else if (xfer) dirty <= 1'b0;
        end
    end
endmodule

module funct_generator_register_bank #(
    parameter int                             DATA_WIDTH = 16,
    parameter int                             NUM_CH     = 4,
    parameter logic [NUM_CH*DATA_WIDTH-1:0]   RESET_VEC  = '0,
    parameter int                             SYNC_MODE  = 1,
    parameter int                             TIMEOUT    = 255,
    parameter int                             ADDR_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clrh,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         commit_req,
    input  logic                         sync,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic [NUM_CH*DATA_WIDTH-1:0] q,
    output logic [NUM_CH-1:0]            dirty,
    output logic                         pending,
    output logic                         commit_done,
    output logic                         timeout,
    output logic                         wr_err
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0][DATA_WIDTH-1:0] shadow;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] active;
    logic [NUM_CH-1:0]                 wr_sel;
    logic [CNT_W-1:0]                  cnt;
    logic                              wr_ok, rd_ok;
    logic                              sync_hit, cnt_hit, xfer, forced;
    logic [IDX_W-1:0]                  rd_idx;

    assign wr_ok  = wr_en && !clrh && (32'(wr_addr) < NUM_CH);
    assign rd_ok  = 32'(rd_addr) < NUM_CH;
    assign rd_idx = IDX_W'(rd_addr);

    // Without sync alignment any latched commit transfers immediately.
    assign sync_hit = (SYNC_MODE == 0) || sync;
    assign cnt_hit  = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT));
    assign xfer     = pending && (sync_hit || cnt_hit);
    // A sync coinciding with the counter limit counts as a sync transfer.
    assign forced   = xfer && !sync_hit;

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            assign wr_sel[i] = wr_ok && (32'(wr_addr) == i);
            funct_generator_register_bank_ch #(
                .DATA_WIDTH (DATA_WIDTH),
                .RST_VAL    (RESET_VEC[i*DATA_WIDTH +: DATA_WIDTH])
            ) u_ch (
                .clk     (clk),
                .rst     (rst),
                .clrh    (clrh),
                .wr      (wr_sel[i]),
                .wr_data (wr_data),
                .xfer    (xfer),
                .shadow  (shadow[i]),
                .active  (active[i]),
                .dirty   (dirty[i])
            );
        end
    endgenerate

    assign q = active;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending     <= 1'b0;
            cnt         <= '0;
            commit_done <= 1'b0;
            timeout     <= 1'b0;
            wr_err      <= 1'b0;
            rd_data     <= '0;
        end else begin
            rd_data     <= rd_ok ? shadow[rd_idx] : '0;
            commit_done <= xfer && !clrh;
            timeout     <= forced && !clrh;
            wr_err      <= wr_en && !clrh && !(32'(wr_addr) < NUM_CH);

            if (clrh || xfer)   pending <= 1'b0;
            else if (commit_req) pending <= 1'b1;

            if (clrh || xfer)
                cnt <= '0;
            else if (pending && !cnt_hit && (TIMEOUT != 0))
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_funct_generator_register_bank.sv
module tb_funct_generator_register_bank;
    localparam int DW = 16;
    localparam int NC = 4;
    localparam logic [63:0] RV = 64'h0004_0003_0002_0001;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          clrh = 0, wr_en = 0, commit_req = 0, sync = 0;
    logic [2:0]    wr_addr = 0, rd_addr = 0;
    logic [DW-1:0] wr_data = 0;
    logic [DW-1:0] rd_data;
    logic [63:0]   q;
    logic [NC-1:0] dirty;
    logic          pending, commit_done, timeout, wr_err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        kind;   // 0 = commit_done event, 1 = wr_err event
        logic [63:0] q;
        logic        to;
        logic [3:0]  dirty;
    } exp_t;
    exp_t sb[$];

    funct_generator_register_bank #(
        .DATA_WIDTH(DW), .NUM_CH(NC), .RESET_VEC(RV),
        .SYNC_MODE(1), .TIMEOUT(8), .ADDR_W(3)
    ) dut (
        .clk(clk), .rst(rst_n), .clrh(clrh), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit_req(commit_req), .sync(sync), .rd_addr(rd_addr),
        .rd_data(rd_data), .q(q), .dirty(dirty), .pending(pending),
        .commit_done(commit_done), .timeout(timeout), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_commit(input logic [63:0] eq, input logic to, input logic [3:0] ed);
        exp_t e;
        e.kind = 1'b0; e.q = eq; e.to = to; e.dirty = ed;
        sb.push_back(e);
    endtask

    task automatic push_wrerr();
        exp_t e;
        e.kind = 1'b1; e.q = '0; e.to = 1'b0; e.dirty = '0;
        sb.push_back(e);
    endtask

    task automatic write(input logic [2:0] a, input logic [15:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 0;
    endtask

    // Latch a commit with no sync, expect the forced transfer at count 8.
    task automatic run_timeout(input logic [63:0] eq, input string tag);
        commit_req = 1;
        tick();
        commit_req = 0;
        for (int k = 0; k < 8; k++) begin
            chk({tag, "_pending"}, 64'(pending), 64'd1);
            tick();
        end
        chk({tag, "_pending_last"}, 64'(pending), 64'd1);
        push_commit(eq, 1'b1, 4'b0000);
        tick();
        chk({tag, "_pending_clr"}, 64'(pending), 64'd0);
        chk({tag, "_q"}, q, eq);
    endtask

    // Monitor: every pulse on commit_done / wr_err must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n && (commit_done || wr_err || timeout)) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: got done=%b to=%b err=%b required none",
                         commit_done, timeout, wr_err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ev_wr_err", 64'(wr_err), 64'(e.kind));
                if (!e.kind) begin
                    chk("ev_commit_done", 64'(commit_done), 64'd1);
                    chk("ev_timeout", 64'(timeout), 64'(e.to));
                    chk("ev_q", q, e.q);
                    chk("ev_dirty", 64'(dirty), 64'(e.dirty));
                end
            end
        end
    end

    initial begin
        // Reset held for 3 cycles
        repeat (3) tick();
        chk("rst_q", q, RV);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_dirty", 64'(dirty), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        rst_n = 1;
        tick();
        chk("idle_q", q, RV);
        chk("idle_pending", 64'(pending), 64'd0);
        chk("idle_dirty", 64'(dirty), 64'd0);

        // Shadow isolation
        write(3'd2, 16'hABCD);
        chk("iso_q", q, RV);
        chk("iso_dirty", 64'(dirty), 64'b0100);
        rd_addr = 3'd2;
        tick();
        chk("iso_rd", 64'(rd_data), 64'hABCD);

        // Synced commit; sync in the commit cycle is ignored
        write(3'd0, 16'h1234);
        commit_req = 1; sync = 1;
        tick();
        commit_req = 0; sync = 0;
        chk("sc_pending_t1", 64'(pending), 64'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("sc_pending_hold", 64'(pending), 64'd1);
            chk("sc_q_hold", q, RV);
        end
        sync = 1;
        push_commit(64'h0004_ABCD_0002_1234, 1'b0, 4'b0000);
        tick();
        sync = 0;
        chk("sc_q", q, 64'h0004_ABCD_0002_1234);
        chk("sc_pending", 64'(pending), 64'd0);
        chk("sc_dirty", 64'(dirty), 64'd0);

        // Timeout, twice to show the counter restarts from 0
        write(3'd3, 16'h7777);
        run_timeout(64'h7777_ABCD_0002_1234, "to1");
        tick();
        run_timeout(64'h7777_ABCD_0002_1234, "to2");

        // Collision: write ch1 in the transfer cycle
        commit_req = 1;
        tick();
        commit_req = 0;
        sync = 1; wr_en = 1; wr_addr = 3'd1; wr_data = 16'h5555; rd_addr = 3'd1;
        push_commit(64'h7777_ABCD_0002_1234, 1'b0, 4'b0010);
        tick();
        sync = 0; wr_en = 0;
        chk("col_q", q, 64'h7777_ABCD_0002_1234);
        chk("col_dirty", 64'(dirty), 64'b0010);
        tick();
        chk("col_rd", 64'(rd_data), 64'h5555);
        commit_req = 1;
        tick();
        commit_req = 0;
        sync = 1;
        push_commit(64'h7777_ABCD_5555_1234, 1'b0, 4'b0000);
        tick();
        sync = 0;
        chk("col2_q", q, 64'h7777_ABCD_5555_1234);

        // Clear beats transfer and write
        write(3'd0, 16'hBEEF);
        commit_req = 1;
        tick();
        commit_req = 0;
        clrh = 1; sync = 1; wr_en = 1; wr_addr = 3'd2; wr_data = 16'h9999;
        tick();
        clrh = 0; sync = 0; wr_en = 0;
        chk("clr_q", q, RV);
        chk("clr_pending", 64'(pending), 64'd0);
        chk("clr_dirty", 64'(dirty), 64'd0);
        rd_addr = 3'd2;
        tick();
        chk("clr_rd2", 64'(rd_data), 64'h0003);
        rd_addr = 3'd0;
        tick();
        chk("clr_rd0", 64'(rd_data), 64'h0001);

        // Out-of-range write and read
        push_wrerr();
        write(3'd5, 16'hDEAD);
        rd_addr = 3'd5;
        tick();
        chk("err_q", q, RV);
        chk("err_dirty", 64'(dirty), 64'd0);
        chk("err_rd", 64'(rd_data), 64'd0);

        // Commit after clear transfers the reset shadows
        commit_req = 1;
        tick();
        commit_req = 0;
        sync = 1;
        push_commit(RV, 1'b0, 4'b0000);
        tick();
        sync = 0;
        chk("post_clr_q", q, RV);

        repeat (3) tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
